// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage core's pipeline sequencing logic.
package pipe_pkg;

    localparam int REG_W = 3;

    // Instruction word loaded into IF/ID on a flush.
    localparam logic [15:0] NOP_INSTR = 16'b0000_1000_0000_0000;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        MSTALL = 2'b01,
        HALT   = 2'b10
    } state_e;

    typedef struct packed {
        logic [REG_W-1:0] wr;
        logic             reg_write;
    } writer_t;

endpackage

// File: rtl/raw_cmp.sv
// Matches one decode source register against the older in-flight writers.
// FORWARD_EN: only a load in ID/EX can produce a match (load-use).
module raw_cmp
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  writer_t          idex,
    input  logic             mem_read_idex,
    input  writer_t          exmem,
    output logic             match
);

`ifdef FORWARD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic idex_hit, exmem_hit;

    assign idex_hit  = idex.reg_write  && (idex.wr  == src);
    assign exmem_hit = exmem.reg_write && (exmem.wr == src);

    // With forwarding, ALU results are bypassed; only load data arrives too late.
    assign match = (idex_hit && (mem_read_idex || !FWD)) || (exmem_hit && !FWD);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: RAW stalls, memory freeze, branch flush, sticky halt.
// Build option FORWARD_EN restricts RAW stalls to load-use in ID/EX.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs_IFID,
    input  logic [REG_W-1:0] Rt_IFID,
    input  logic             RsUsed_IFID,
    input  logic             RtUsed_IFID,
    input  logic [REG_W-1:0] WrR_IDEX,
    input  logic             RegWrite_IDEX,
    input  logic             MemRead_IDEX,
    input  logic [REG_W-1:0] WrR_EXMEM,
    input  logic             RegWrite_EXMEM,
    input  logic             takeBranch_EXMEM,
    input  logic             Dump_MEMWB,
    input  logic             memBusy,
    output logic             stallCtrl,
    output logic             pcEn,
    output logic             ifidEn,
    output logic             flush_IFID,
    output logic             pipeEn,
    output logic             halt,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    localparam int NSRC = 2;

    logic [NSRC-1:0][REG_W-1:0] src;
    logic [NSRC-1:0]            used;
    logic [NSRC-1:0]            hit;
    writer_t                    idex, exmem;
    logic                       raw;

    state_e state, state_nx;
    logic   inc_stall, inc_flush;

    assign src   = {Rt_IFID, Rs_IFID};
    assign used  = {RtUsed_IFID, RsUsed_IFID};
    assign idex  = '{wr: WrR_IDEX,  reg_write: RegWrite_IDEX};
    assign exmem = '{wr: WrR_EXMEM, reg_write: RegWrite_EXMEM};

    for (genvar g = 0; g < NSRC; g++) begin : g_cmp
        raw_cmp u_cmp (
            .src           (src[g]),
            .idex          (idex),
            .mem_read_idex (MemRead_IDEX),
            .exmem         (exmem),
            .match         (hit[g])
        );
    end

    assign raw = |(used & hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        pcEn       = 1'b1;
        ifidEn     = 1'b1;
        pipeEn     = 1'b1;
        stallCtrl  = 1'b0;
        flush_IFID = 1'b0;
        inc_stall  = 1'b0;
        inc_flush  = 1'b0;
        case (state)
            HALT: begin
                pcEn      = 1'b0;
                ifidEn    = 1'b0;
                pipeEn    = 1'b0;
                stallCtrl = 1'b1;
            end
            default: begin
                // MSTALL exit falls straight into the RUN rules in the same cycle.
                if (memBusy) begin
                    pcEn     = 1'b0;
                    ifidEn   = 1'b0;
                    pipeEn   = 1'b0;
                    state_nx = MSTALL;
                end else begin
                    state_nx = Dump_MEMWB ? HALT : RUN;
                    if (takeBranch_EXMEM) begin
                        flush_IFID = 1'b1;
                        inc_flush  = 1'b1;
                    end else if (raw) begin
                        pcEn      = 1'b0;
                        ifidEn    = 1'b0;
                        stallCtrl = 1'b1;
                        inc_stall = 1'b1;
                    end
                end
            end
        endcase
    end

    assign halt = (state == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (inc_stall && (stallCnt != '1)) stallCnt <= stallCnt + 1'b1;
            if (inc_flush && (flushCnt != '1)) flushCnt <= flushCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (default build, CNT_W=4).
module tb_hazard_ctrl;

    localparam int CW = 4;

    logic          clk, rst;
    logic [2:0]    Rs_IFID, Rt_IFID, WrR_IDEX, WrR_EXMEM;
    logic          RsUsed_IFID, RtUsed_IFID, RegWrite_IDEX, MemRead_IDEX;
    logic          RegWrite_EXMEM, takeBranch_EXMEM, Dump_MEMWB, memBusy;
    logic          stallCtrl, pcEn, ifidEn, flush_IFID, pipeEn, halt;
    logic [CW-1:0] stallCnt, flushCnt;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .Rs_IFID          (Rs_IFID),
        .Rt_IFID          (Rt_IFID),
        .RsUsed_IFID      (RsUsed_IFID),
        .RtUsed_IFID      (RtUsed_IFID),
        .WrR_IDEX         (WrR_IDEX),
        .RegWrite_IDEX    (RegWrite_IDEX),
        .MemRead_IDEX     (MemRead_IDEX),
        .WrR_EXMEM        (WrR_EXMEM),
        .RegWrite_EXMEM   (RegWrite_EXMEM),
        .takeBranch_EXMEM (takeBranch_EXMEM),
        .Dump_MEMWB       (Dump_MEMWB),
        .memBusy          (memBusy),
        .stallCtrl        (stallCtrl),
        .pcEn             (pcEn),
        .ifidEn           (ifidEn),
        .flush_IFID       (flush_IFID),
        .pipeEn           (pipeEn),
        .halt             (halt),
        .stallCnt         (stallCnt),
        .flushCnt         (flushCnt)
    );

    typedef struct packed {
        logic       rst;
        logic [2:0] rs, rt;
        logic       rsu, rtu;
        logic [2:0] wi;
        logic       rwi, mri;
        logic [2:0] we;
        logic       rwe, br, dump, busy;
    } stim_t;

    // {pcEn, ifidEn, pipeEn, stallCtrl, flush_IFID}
    localparam logic [4:0] IDLE  = 5'b11100;
    localparam logic [4:0] FRZ   = 5'b00000;
    localparam logic [4:0] RAWS  = 5'b00110;
    localparam logic [4:0] BR    = 5'b11101;
    localparam logic [4:0] HALTC = 5'b00010;

    logic [13:0] exp_q[$];
    string       tag_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] ex(input logic [4:0] c, input logic h,
                                       input int sc, input int fc);
        return {c, h, CW'(sc), CW'(fc)};
    endfunction

    task automatic step(input string tag, input stim_t s, input logic [13:0] e);
        logic [13:0] obs, want;
        string       t;
        @(posedge clk);
        #1;
        rst = s.rst; Rs_IFID = s.rs; Rt_IFID = s.rt;
        RsUsed_IFID = s.rsu; RtUsed_IFID = s.rtu;
        WrR_IDEX = s.wi; RegWrite_IDEX = s.rwi; MemRead_IDEX = s.mri;
        WrR_EXMEM = s.we; RegWrite_EXMEM = s.rwe;
        takeBranch_EXMEM = s.br; Dump_MEMWB = s.dump; memBusy = s.busy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        obs  = {pcEn, ifidEn, pipeEn, stallCtrl, flush_IFID, halt, stallCnt, flushCnt};
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        vectors++;
        assert (obs === want)
        else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", t, obs, want);
        end
    endtask

    stim_t idle_s, raw_i, raw_e, raw_t, s;

    initial begin
        idle_s = '0;
        raw_i = '0; raw_i.rs = 3'd3; raw_i.rsu = 1'b1; raw_i.wi = 3'd3; raw_i.rwi = 1'b1;
        raw_e = '0; raw_e.rs = 3'd3; raw_e.rsu = 1'b1; raw_e.we = 3'd3; raw_e.rwe = 1'b1;
        raw_t = '0; raw_t.rt = 3'd5; raw_t.rtu = 1'b1; raw_t.wi = 3'd5; raw_t.rwi = 1'b1;

        rst = 1'b1;
        {Rs_IFID, Rt_IFID, RsUsed_IFID, RtUsed_IFID, WrR_IDEX, RegWrite_IDEX,
         MemRead_IDEX, WrR_EXMEM, RegWrite_EXMEM, takeBranch_EXMEM,
         Dump_MEMWB, memBusy} = '0;

        s = idle_s; s.rst = 1'b1;
        step("reset", s, ex(IDLE, 0, 0, 0));
        step("idle", idle_s, ex(IDLE, 0, 0, 0));
        s = raw_i; s.rsu = 1'b0;
        step("rs_not_used", s, ex(IDLE, 0, 0, 0));
        s = raw_i; s.rwi = 1'b0;
        step("idex_no_write", s, ex(IDLE, 0, 0, 0));

        step("raw_idex", raw_i, ex(RAWS, 0, 0, 0));
        step("raw_exmem", raw_e, ex(RAWS, 0, 1, 0));
        step("raw_clear", idle_s, ex(IDLE, 0, 2, 0));
        step("raw_rt", raw_t, ex(RAWS, 0, 2, 0));
        step("raw_rt_clear", idle_s, ex(IDLE, 0, 3, 0));

        s = raw_i; s.br = 1'b1;
        step("branch_over_raw", s, ex(BR, 0, 3, 0));
        step("branch_cnt", idle_s, ex(IDLE, 0, 3, 1));

        s = raw_i; s.busy = 1'b1;
        for (int i = 0; i < 3; i++) step("busy_raw", s, ex(FRZ, 0, 3, 1));
        step("busy_exit_raw", raw_i, ex(RAWS, 0, 3, 1));
        step("busy_exit_clear", idle_s, ex(IDLE, 0, 4, 1));

        s = idle_s; s.br = 1'b1; s.busy = 1'b1;
        step("busy_branch", s, ex(FRZ, 0, 4, 1));
        s.busy = 1'b0;
        step("busy_exit_branch", s, ex(BR, 0, 4, 1));
        step("branch_cnt2", idle_s, ex(IDLE, 0, 4, 2));

        s = idle_s; s.busy = 1'b1;
        step("enter_mstall", s, ex(FRZ, 0, 4, 2));
        s = idle_s; s.rst = 1'b1;
        step("rst_mid_mstall", s, ex(IDLE, 0, 0, 0));
        step("after_rst", idle_s, ex(IDLE, 0, 0, 0));

        s = idle_s; s.dump = 1'b1; s.busy = 1'b1;
        step("dump_busy", s, ex(FRZ, 0, 0, 0));
        s.busy = 1'b0;
        step("dump_retire", s, ex(IDLE, 0, 0, 0));
        s = raw_i; s.br = 1'b1; s.busy = 1'b1;
        step("halt_busy_br", s, ex(HALTC, 1, 0, 0));
        step("halt_raw", raw_i, ex(HALTC, 1, 0, 0));
        s = idle_s; s.br = 1'b1;
        step("halt_br", s, ex(HALTC, 1, 0, 0));
        s = idle_s; s.rst = 1'b1;
        step("rst_mid_halt", s, ex(IDLE, 0, 0, 0));
        step("after_rst2", idle_s, ex(IDLE, 0, 0, 0));

        for (int i = 0; i < (1 << CW) + 5; i++)
            step("sat_stall", raw_i, ex(RAWS, 0, (i > 15) ? 15 : i, 0));
        step("sat_hold", idle_s, ex(IDLE, 0, 15, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing unit for the 5-stage core.
- Detects RAW hazards between the instruction in IF/ID and older in-flight writers, and drives the decode stage's stallCtrl.
- Freezes the whole pipeline while data/instruction memory is busy, and issues IF/ID flushes on taken branches.
- Latches a permanent halt once a Dump instruction retires. Sits beside decode; its outputs go to the PC register, the IF/ID register, and the decode stall mux.

Parameters:
- CNT_W, 16: width of the saturating performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- Rs_IFID  in  3  instr_IFID[10:8], source register 1 of the decoding instruction
- Rt_IFID  in  3  instr_IFID[7:5], source register 2
- RsUsed_IFID  in  1  decoding instruction reads Rs
- RtUsed_IFID  in  1  decoding instruction reads Rt
- WrR_IDEX  in  3  destination register in ID/EX
- RegWrite_IDEX  in  1  ID/EX writes the register file
- MemRead_IDEX  in  1  ID/EX is a load
- WrR_EXMEM  in  3  destination register in EX/MEM
- RegWrite_EXMEM  in  1  EX/MEM writes the register file
- takeBranch_EXMEM  in  1  resolved taken branch/jump in EX/MEM
- Dump_MEMWB  in  1  halt instruction in MEM/WB
- memBusy  in  1  instruction or data memory not ready this cycle
- stallCtrl  out  1  bubble request to decode (zeroes RegWrite/MemWrite into ID/EX)
- pcEn  out  1  PC register enable
- ifidEn  out  1  IF/ID register enable
- flush_IFID  out  1  load NOP into IF/ID
- pipeEn  out  1  enable for ID/EX, EX/MEM and MEM/WB registers
- halt  out  1  core halted (sticky)
- stallCnt  out  CNT_W  RAW stall cycles, saturating
- flushCnt  out  CNT_W  branch flushes, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- FSM states: RUN, MSTALL, HALT. Reset to RUN; halt=0; stallCnt=0; flushCnt=0.
- Control outputs are combinational from the state and the current inputs, so they act in the same cycle. State and counters are registered.
- With idle inputs out of reset, the outputs are: pcEn=1, ifidEn=1, pipeEn=1, stallCtrl=0, flush_IFID=0.
- RAW hazard: raw = (RsUsed & match(Rs)) | (RtUsed & match(Rt)).
  - match(r) = (RegWrite_IDEX & WrR_IDEX==r) | (RegWrite_EXMEM & WrR_EXMEM==r).
  - MEM/WB writers are covered by the register file's write-before-read, so they never cause a stall.
- Priority per cycle: HALT > memBusy > takeBranch_EXMEM > raw.
- HALT state: pcEn=ifidEn=pipeEn=0, stallCtrl=1, halt=1. The core leaves HALT only on rst.
- RUN, Dump_MEMWB=1 (any other inputs): next state HALT. This cycle's outputs follow the normal RUN rules so the Dump retires.
- RUN, memBusy=1: pcEn=ifidEn=pipeEn=0, stallCtrl=0. Next state MSTALL.
- MSTALL: outputs are the same freeze as above. Stay while memBusy=1. When memBusy=0, go to RUN and, in that same cycle, apply the RUN rules below.
  - A branch or hazard held during the freeze is therefore acted on at exit, because the EX/MEM contents were held.
- RUN, takeBranch_EXMEM=1: pcEn=1 (loads target), ifidEn=1, flush_IFID=1, stallCtrl=0, pipeEn=1. flushCnt++.
  - A branch overrides a simultaneous raw, because the younger instruction is being discarded anyway.
- RUN, raw=1: pcEn=0, ifidEn=0, stallCtrl=1, pipeEn=1. This inserts one bubble per cycle until raw clears (at most 2 cycles). stallCnt++.
- Counters saturate at all-ones and do not wrap. They do not increment in MSTALL or HALT.
- Dump_MEMWB and memBusy in the same cycle: memBusy wins. Enter HALT only after the freeze ends and Dump_MEMWB is still 1.
- rst mid-stall or mid-halt: immediate return to RUN with counters cleared.

Optional Feature:
- Macro FORWARD_EN.
- Defined: an EX-stage forwarding path exists.
  - match() only considers ID/EX, and only when MemRead_IDEX=1 (load-use). This gives a 1-cycle stall.
  - EX/MEM writers never stall.
- Undefined: full RAW rule above.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding constants (RUN=2'b00, MSTALL=2'b01, HALT=2'b10);
  - the NOP instruction encoding used by the IF/ID flush;
  - the register-index width (3).
- One natural sub-module: raw_cmp, a pure comparator. It computes match for one source register against the ID/EX and EX/MEM destinations and is instantiated twice.

Test Plan:
- Reset, then idle inputs → pcEn=1, ifidEn=1, pipeEn=1, stallCtrl=0, halt=0, counters=0. Assert rst mid-MSTALL → RUN next, outputs idle.
- ID/EX writes r3; IF/ID reads Rs=r3 with RsUsed=1 → stallCtrl=1, pcEn=0 for 2 cycles (1 cycle with FORWARD_EN and MemRead_IDEX=1, 0 cycles if not a load). stallCnt=2 (or 1).
- takeBranch_EXMEM=1 with a simultaneous raw → flush_IFID=1, pcEn=1, stallCtrl=0, flushCnt=1, stallCnt unchanged.
- memBusy high for 3 cycles during a raw → pipeEn=0 for 3 cycles, stallCnt unchanged; raw stall resumes on exit.
- Dump_MEMWB=1 → halt=1 from the next cycle, all enables 0, persists with arbitrary inputs until rst.
- Force 2^CNT_W+5 raw cycles (CNT_W=4) → stallCnt holds at 4'hF.
